tree_walker: RTL

Control stage directly upstream of the comparator in the SADDC decision-tree datapath. It buffers one sample's feature vector and holds the tree's node table. For each internal node it issues a {feature, weights} request to the comparator, consumes the 1-bit decision, and follows the left or right child until it reaches a leaf. It then emits that leaf's class label. Exactly one sample is in flight at a time.

---
 rtl/tree_walker_if.sv | 58 +++++
 rtl/tree_walker.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tree_walker_if.sv
// Handshake and node-table configuration bundle for tree_walker.
// The slave modport is the walker; the master modport is the surrounding datapath.
interface tree_walker_if #(
    parameter int FEAT_W  = 32,
    parameter int N_FEAT  = 16,
    parameter int N_NODES = 64,
    parameter int CLASS_W = 8
);
    localparam int FI_W  = $clog2(N_FEAT);
    localparam int NA_W  = $clog2(N_NODES);
    localparam int CFG_W = 1 + FI_W + 2 * NA_W + FEAT_W;

    logic               cfg_wr_en;
    logic [NA_W-1:0]    cfg_wr_addr;
    logic [CFG_W-1:0]   cfg_wr_data;

    logic               in_valid;
    logic               in_ready;
    logic [FEAT_W-1:0]  in_bits_feature;

    logic               cmp_req_valid;
    logic               cmp_req_ready;
    logic [FEAT_W-1:0]  cmp_req_bits_feature;
    logic [FEAT_W-1:0]  cmp_req_bits_weights;

    logic               cmp_resp_valid;
    logic               cmp_resp_ready;
    logic               cmp_resp_bits_decision;

    logic               out_valid;
    logic               out_ready;
    logic [CLASS_W-1:0] out_bits_class;
    logic               out_bits_error;

    modport master (
        output cfg_wr_en, cfg_wr_addr, cfg_wr_data,
        output in_valid, in_bits_feature,
        input  in_ready,
        input  cmp_req_valid, cmp_req_bits_feature, cmp_req_bits_weights,
        output cmp_req_ready,
        output cmp_resp_valid, cmp_resp_bits_decision,
        input  cmp_resp_ready,
        input  out_valid, out_bits_class, out_bits_error,
        output out_ready
    );

    modport slave (
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_data,
        input  in_valid, in_bits_feature,
        output in_ready,
        output cmp_req_valid, cmp_req_bits_feature, cmp_req_bits_weights,
        input  cmp_req_ready,
        input  cmp_resp_valid, cmp_resp_bits_decision,
        output cmp_resp_ready,
        output out_valid, out_bits_class, out_bits_error,
        input  out_ready
    );
endinterface

// File: rtl/tree_walker.sv
// Decision-tree walker: buffers one feature vector, walks the node table via an external
// comparator and emits the leaf class. Define TREE_WALKER_DEPTH_GUARD_EN for the depth guard.
module tree_walker #(
    parameter int FEAT_W    = 32,
    parameter int N_FEAT    = 16,
    parameter int N_NODES   = 64,
`ifdef TREE_WALKER_DEPTH_GUARD_EN
    parameter int MAX_DEPTH = 16,
`endif
    parameter int CLASS_W   = 8
) (
    input logic          clk,
    input logic          reset,
    tree_walker_if.slave bus
);
    localparam int FI_W = $clog2(N_FEAT);
    localparam int NA_W = $clog2(N_NODES);

    typedef enum logic [2:0] {
        S_LOAD, S_FETCH, S_EVAL, S_ISSUE, S_WAIT, S_DONE
    } state_e;

    typedef struct packed {
        logic              is_leaf;
        logic [FI_W-1:0]   feat_idx;
        logic [NA_W-1:0]   left;
        logic [NA_W-1:0]   right;
        logic [FEAT_W-1:0] weights;
    } node_t;

    node_t             node_mem [N_NODES];
    logic [FEAT_W-1:0] feat_buf [N_FEAT];
    node_t             node_rd_q;

    state_e             state_q, state_d;
    logic [FI_W-1:0]    cnt_q, cnt_d;
    logic [NA_W-1:0]    node_q, node_d;
    logic [CLASS_W-1:0] class_q, class_d;
    logic [FEAT_W-1:0]  req_feat_q, req_feat_d;
    logic [FEAT_W-1:0]  req_wgt_q, req_wgt_d;
    logic               in_ready_q, in_ready_d;
    logic               req_valid_q, req_valid_d;
    logic               resp_ready_q, resp_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               in_fire;

`ifdef TREE_WALKER_DEPTH_GUARD_EN
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               error_q, error_d;
`endif

    // in_ready_q is only ever high in LOAD, so it doubles as the load-state qualifier.
    assign in_fire = in_ready_q && bus.in_valid;

    // NOTE: the node table and feature buffer are plain storage with no reset, so they map
    // onto RAM; the table must survive a mid-walk reset anyway.
    always_ff @(posedge clk) begin
        if (bus.cfg_wr_en && state_q == S_LOAD) begin
            node_mem[bus.cfg_wr_addr] <= node_t'(bus.cfg_wr_data);
        end
        if (in_fire) begin
            feat_buf[cnt_q] <= bus.in_bits_feature;
        end
        if (state_q == S_FETCH) begin
            node_rd_q <= node_mem[node_q];
        end
    end

    // NOTE: every variable gets its hold value first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        node_d     = node_q;
        class_d    = class_q;
        req_feat_d = req_feat_q;
        req_wgt_d  = req_wgt_q;
`ifdef TREE_WALKER_DEPTH_GUARD_EN
        depth_d    = depth_q;
        error_d    = error_q;
`endif
        unique case (state_q)
            S_LOAD: begin
                if (in_fire) begin
                    if (cnt_q == FI_W'(N_FEAT - 1)) begin
                        cnt_d   = '0;
                        node_d  = '0;
`ifdef TREE_WALKER_DEPTH_GUARD_EN
                        depth_d = '0;
`endif
                        state_d = S_FETCH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FETCH: state_d = S_EVAL;
            S_EVAL: begin
                if (node_rd_q.is_leaf) begin
                    class_d = node_rd_q.weights[CLASS_W-1:0];
`ifdef TREE_WALKER_DEPTH_GUARD_EN
                    error_d = 1'b0;
`endif
                    state_d = S_DONE;
`ifdef TREE_WALKER_DEPTH_GUARD_EN
                end else if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
                    class_d = '0;
                    error_d = 1'b1;
                    state_d = S_DONE;
`endif
                end else begin
                    req_feat_d = feat_buf[node_rd_q.feat_idx];
                    req_wgt_d  = node_rd_q.weights;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.cmp_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.cmp_resp_valid) begin
                    // node_rd_q still holds the node being decided; child pointers wrap freely.
                    node_d  = bus.cmp_resp_bits_decision ? node_rd_q.right : node_rd_q.left;
`ifdef TREE_WALKER_DEPTH_GUARD_EN
                    depth_d = depth_q + 1'b1;
`endif
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase

        in_ready_d   = (state_d == S_LOAD);
        req_valid_d  = (state_d == S_ISSUE);
        resp_ready_d = (state_d == S_WAIT);
        out_valid_d  = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_LOAD;
            cnt_q        <= '0;
            node_q       <= '0;
            class_q      <= '0;
            req_feat_q   <= '0;
            req_wgt_q    <= '0;
            in_ready_q   <= 1'b1;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
`ifdef TREE_WALKER_DEPTH_GUARD_EN
            depth_q      <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            node_q       <= node_d;
            class_q      <= class_d;
            req_feat_q   <= req_feat_d;
            req_wgt_q    <= req_wgt_d;
            in_ready_q   <= in_ready_d;
            req_valid_q  <= req_valid_d;
            resp_ready_q <= resp_ready_d;
            out_valid_q  <= out_valid_d;
`ifdef TREE_WALKER_DEPTH_GUARD_EN
            depth_q      <= depth_d;
            error_q      <= error_d;
`endif
        end
    end

    assign bus.in_ready             = in_ready_q;
    assign bus.cmp_req_valid        = req_valid_q;
    assign bus.cmp_req_bits_feature = req_feat_q;
    assign bus.cmp_req_bits_weights = req_wgt_q;
    assign bus.cmp_resp_ready       = resp_ready_q;
    assign bus.out_valid            = out_valid_q;
    assign bus.out_bits_class       = class_q;
`ifdef TREE_WALKER_DEPTH_GUARD_EN
    assign bus.out_bits_error       = error_q;
`else
    assign bus.out_bits_error       = 1'b0;
`endif
endmodule
